// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA plot controller.
package vga_pkg;

  localparam int unsigned XRES_DEF = 160;
  localparam int unsigned YRES_DEF = 120;
  localparam int unsigned CW       = 3;

  localparam logic [1:0] REG_X   = 2'd0;
  localparam logic [1:0] REG_Y   = 2'd1;
  localparam logic [1:0] REG_COL = 2'd2;
  localparam logic [1:0] REG_CMD = 2'd3;

  typedef enum logic {OP_PLOT, OP_FILL} opcode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PLOT, ST_FILL} state_t;

  typedef struct packed {
    opcode_t       op;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [CW-1:0] colour;
  } plot_cmd_t;

endpackage

// File: rtl/vga_plot_ctrl_if.sv
// CPU port-write bus into the plot controller.
interface vga_plot_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/plot_fifo.sv
// Synchronous command FIFO; a push into a full queue succeeds only alongside a pop.
module plot_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  plot_cmd_t                din,
  output plot_cmd_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  plot_cmd_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_cnt;
  logic           w_do_pop;
  logic           w_do_push;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign count     = r_cnt;
  assign dout      = r_mem[r_rd];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/vga_plot_ctrl.sv
// CPU write staging, command queue and pixel FSM driving vga_adapter.
// Colour width comes from vga_pkg::CW so queue entries and ports always agree.
module vga_plot_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned XRES       = XRES_DEF,
  parameter int unsigned YRES       = YRES_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  vga_plot_ctrl_if.slave  cpu,
  output logic [7:0]      vga_x,
  output logic [6:0]      vga_y,
  output logic [CW-1:0]   vga_colour,
  output logic            vga_plot,
  output logic            busy,
  output logic            overflow
);
  localparam logic [7:0] XLAST = 8'(XRES - 1);
  localparam logic [6:0] YLAST = 7'(YRES - 1);
  localparam logic [8:0] XLIM  = 9'(XRES);
  localparam logic [7:0] YLIM  = 8'(YRES);

  logic [7:0]    r_sx;
  logic [6:0]    r_sy;
  logic [CW-1:0] r_scol;
  logic          r_ovf;
  state_t        r_state, w_nxt_state;
  logic [7:0]    r_x, w_nxt_x;
  logic [6:0]    r_y, w_nxt_y;
  logic [CW-1:0] r_col, w_nxt_col;
  logic          r_plot, w_nxt_plot;

  logic          w_cmd, w_push, w_pop, w_full, w_empty;
  plot_cmd_t     w_cmd_pkt, w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  assign w_cmd  = cpu.wr_en && (cpu.wr_addr == REG_CMD);
  assign w_push = w_cmd && (cpu.wr_data[1] || cpu.wr_data[0]);

  always_comb begin
    w_cmd_pkt        = '0;
    w_cmd_pkt.op     = cpu.wr_data[1] ? OP_FILL : OP_PLOT;
    w_cmd_pkt.x      = r_sx;
    w_cmd_pkt.y      = r_sy;
    w_cmd_pkt.colour = r_scol;
  end

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_cmd_pkt),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_scol <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (cpu.wr_en && cpu.wr_addr == REG_X)   r_sx   <= cpu.wr_data;
      if (cpu.wr_en && cpu.wr_addr == REG_Y)   r_sy   <= cpu.wr_data[6:0];
      if (cpu.wr_en && cpu.wr_addr == REG_COL) r_scol <= cpu.wr_data[CW-1:0];
      // A dropped push wins over a same-cycle clear request.
      if (w_push && w_full && !w_pop)       r_ovf <= 1'b1;
      else if (w_cmd && cpu.wr_data[7])     r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_x     = r_x;
    w_nxt_y     = r_y;
    w_nxt_col   = r_col;
    w_nxt_plot  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_nxt_col = w_head.colour;
          if (w_head.op == OP_FILL) begin
            w_nxt_x     = '0;
            w_nxt_y     = '0;
            w_nxt_plot  = 1'b1;
            w_nxt_state = ST_FILL;
          end else begin
            w_nxt_x     = w_head.x;
            w_nxt_y     = w_head.y;
            w_nxt_plot  = ({1'b0, w_head.x} < XLIM) && ({1'b0, w_head.y} < YLIM);
            w_nxt_state = ST_PLOT;
          end
        end
      end
      ST_PLOT: w_nxt_state = ST_IDLE;
      ST_FILL: begin
        if (r_x == XLAST) begin
          if (r_y == YLAST) begin
            w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_x    = '0;
            w_nxt_y    = r_y + 1'b1;
            w_nxt_plot = 1'b1;
          end
        end else begin
          w_nxt_x    = r_x + 1'b1;
          w_nxt_plot = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_plot  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_x     <= w_nxt_x;
      r_y     <= w_nxt_y;
      r_col   <= w_nxt_col;
      r_plot  <= w_nxt_plot;
    end
  end

  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_col;
  assign vga_plot   = r_plot;
  assign overflow   = r_ovf;
  assign busy       = (r_state != ST_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_vga_plot_ctrl.sv
// Directed self-checking bench for vga_plot_ctrl.
module tb_vga_plot_ctrl;
  import vga_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot, busy, overflow;

  vga_plot_ctrl_if bus ();

  vga_plot_ctrl #(.XRES(160), .YRES(120), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (bus),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c; int cyc;} rec_t;
  rec_t plog[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vga_plot === 1'b1) plog.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cyc});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; the write is sampled at the next edge, returns #1 after it.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    bit to;
    int bad;
    bit found;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    #22 reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_x", 32'(vga_x), 0);
    check_val("rst_y", 32'(vga_y), 0);
    check_val("rst_col", 32'(vga_colour), 0);
    check_val("rst_plot", 32'(vga_plot), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_ovf", 32'(overflow), 0);

    // single plot
    wr(REG_X, 8'd10); wr(REG_Y, 8'd20); wr(REG_COL, 8'd5); wr(REG_CMD, 8'h01);
    check_val("p1_busy_n", 32'(busy), 1);
    check_val("p1_plot_n", 32'(vga_plot), 0);
    @(posedge clk); #1;
    check_val("p1_plot", 32'(vga_plot), 1);
    check_val("p1_x", 32'(vga_x), 10);
    check_val("p1_y", 32'(vga_y), 20);
    check_val("p1_col", 32'(vga_colour), 5);
    @(posedge clk); #1;
    check_val("p1_plot_end", 32'(vga_plot), 0);
    check_val("p1_busy_end", 32'(busy), 0);
    check_val("p1_npix", 32'(plog.size()), 1);

    // out-of-range plot is dropped
    plog.delete();
    wr(REG_X, 8'd200); wr(REG_CMD, 8'h01);
    check_val("p2_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check_val("p2_plot", 32'(vga_plot), 0);
    @(posedge clk); #1;
    check_val("p2_busy_end", 32'(busy), 0);
    check_val("p2_ovf", 32'(overflow), 0);
    check_val("p2_npix", 32'(plog.size()), 0);

    // full-screen fill
    wr(REG_COL, 8'd3); wr(REG_CMD, 8'h03);
    wait_idle(19400, to);
    check_val("p3_timeout", 32'(to), 0);
    check_val("p3_npix", 32'(plog.size()), 19200);
    if (plog.size() == 19200) begin
      bad = 0;
      for (int i = 0; i < 19200; i++)
        if (plog[i].x != i % 160 || plog[i].y != i / 160 || plog[i].c != 3 || plog[i].cyc != plog[0].cyc + i)
          bad++;
      check_val("p3_raster_bad", 32'(bad), 0);
    end

    // queue during fill, overflow, clear, then push in the pop cycle
    plog.delete();
    wr(REG_CMD, 8'h03);
    wr(REG_Y, 8'd7); wr(REG_COL, 8'd6);
    for (int k = 1; k <= 4; k++) begin
      wr(REG_X, 8'(k)); wr(REG_CMD, 8'h01);
    end
    check_val("p4_ovf_pre", 32'(overflow), 0);
    wr(REG_X, 8'd5); wr(REG_CMD, 8'h01);
    check_val("p4_ovf_set", 32'(overflow), 1);
    wr(REG_CMD, 8'h80);
    check_val("p4_ovf_clr", 32'(overflow), 0);
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (vga_plot && vga_x == 8'd159 && vga_y == 7'd119) begin
        found = 1'b1;
        break;
      end
    end
    check_val("p4_fill_end_seen", 32'(found), 1);
    @(posedge clk); #1;
    wr(REG_CMD, 8'h01);
    check_val("p6_ovf_popcycle", 32'(overflow), 0);
    wait_idle(100, to);
    check_val("p4_timeout", 32'(to), 0);
    check_val("p4_npix", 32'(plog.size()), 19205);
    if (plog.size() == 19205) begin
      for (int k = 0; k < 5; k++) begin
        check_val($sformatf("p4_px%0d_x", k), 32'(plog[19200+k].x), 32'(k + 1));
        check_val($sformatf("p4_px%0d_y", k), 32'(plog[19200+k].y), 7);
        check_val($sformatf("p4_px%0d_c", k), 32'(plog[19200+k].c), 6);
      end
      check_val("p4_spacing", 32'(plog[19202].cyc - plog[19201].cyc), 2);
    end

    // reset mid-fill
    wr(REG_COL, 8'd2); wr(REG_CMD, 8'h03);
    repeat (100) @(posedge clk);
    #1;
    check_val("p5_plot_pre", 32'(vga_plot), 1);
    #2 reset = 1'b1;
    #1;
    check_val("p5_plot_rst", 32'(vga_plot), 0);
    check_val("p5_busy_rst", 32'(busy), 0);
    check_val("p5_x_rst", 32'(vga_x), 0);
    #20 reset = 1'b0;
    plog.delete();
    repeat (50) @(posedge clk);
    #1;
    check_val("p5_npix", 32'(plog.size()), 0);
    check_val("p5_busy", 32'(busy), 0);
    check_val("p5_col", 32'(vga_colour), 0);
    check_val("p5_ovf", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
